// File: rtl/nco_pkg.sv
// Shared defaults and FSM state encoding for the NCO phase generator.
package nco_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int IDX_W_DEF = 7;
    localparam int DIV_W_DEF = 12;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_RUN       = 2'd1;
    localparam state_t ST_HALT_PEND = 2'd2;

endpackage

// File: rtl/nco_tick_div.sv
// Reloadable down-counter: tick_o marks a sample boundary every div+1 cycles
// while run_i is high.
module nco_tick_div
    import nco_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             run_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;

    assign tick_o = run_i && (cnt_q == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            div_q <= '0;
        end else if (load_i) begin
            cnt_q <= div_i;
            div_q <= div_i;
        end else if (run_i) begin
            if (cnt_q == '0) cnt_q <= div_q;
            else             cnt_q <= cnt_q - DIV_W'(1);
        end
    end

endmodule

// File: rtl/nco_phase_gen.sv
// Phase accumulator NCO: emits a registered sine-table index and strobe at each
// sample boundary, with a one-entry shadow for glitch-free retuning while running.
module nco_phase_gen
    import nco_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [ACC_W-1:0] cfg_ftw,
    input  logic [IDX_W-1:0] cfg_poff,
    output logic [IDX_W-1:0] lookup,
    output logic             en,
    output logic             wrap,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] ftw_q;
    logic [IDX_W-1:0] poff_q;
    logic [ACC_W-1:0] shadow_ftw_q;
    logic [IDX_W-1:0] shadow_poff_q;
    logic             shadow_full_q;
    logic [IDX_W-1:0] lookup_q;
    logic             en_q;
    logic             wrap_q;

    logic             idle;
    logic             start_acc;
    logic             tick;
    logic             xfer;
    logic [ACC_W:0]   sum;
    logic [IDX_W-1:0] idx_next;

    assign idle      = (state_q == ST_IDLE);
    assign start_acc = idle && start;
    assign busy      = !idle;
    assign cfg_ready = idle || !shadow_full_q;
    assign xfer      = cfg_valid && cfg_ready;

    // Carry out of the extra top bit is the wrap indication.
    assign sum      = {1'b0, acc_q} + {1'b0, ftw_q};
    assign idx_next = sum[ACC_W-1 -: IDX_W] + poff_q;

    nco_tick_div #(
        .DIV_W (DIV_W)
    ) u_tick_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (start_acc),
        .div_i  (div),
        .run_i  (busy),
        .tick_o (tick)
    );

    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_RUN;
            ST_RUN:       if (stop)  state_d = ST_HALT_PEND;
            ST_HALT_PEND: if (tick)  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            lookup_q <= '0;
            en_q     <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= tick;
            wrap_q  <= tick && sum[ACC_W];
            if (start_acc) begin
                acc_q <= '0;
            end else if (tick) begin
                acc_q    <= sum[ACC_W-1:0];
                lookup_q <= idx_next;
            end
        end
    end

    // A boundary consumes the old tuning first; cfg_ready is low whenever the
    // shadow is full, so an apply and a new shadow load never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw_q         <= '0;
            poff_q        <= '0;
            shadow_ftw_q  <= '0;
            shadow_poff_q <= '0;
            shadow_full_q <= 1'b0;
        end else if (idle) begin
            if (xfer) begin
                ftw_q  <= cfg_ftw;
                poff_q <= cfg_poff;
            end
        end else begin
            if (tick && shadow_full_q) begin
                ftw_q         <= shadow_ftw_q;
                poff_q        <= shadow_poff_q;
                shadow_full_q <= 1'b0;
            end
            if (xfer) begin
                shadow_ftw_q  <= cfg_ftw;
                shadow_poff_q <= cfg_poff;
                shadow_full_q <= 1'b1;
            end
        end
    end

    assign lookup = lookup_q;
    assign en     = en_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed bench for nco_phase_gen: ramp, fast run, retune, stop and reset scenarios.
module tb_nco_phase_gen;

    localparam int ACC_W = 24;
    localparam int IDX_W = 7;
    localparam int DIV_W = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [DIV_W-1:0] div = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [ACC_W-1:0] cfg_ftw = '0;
    logic [IDX_W-1:0] cfg_poff = '0;
    logic [IDX_W-1:0] lookup;
    logic             en;
    logic             wrap;
    logic             busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    nco_phase_gen #(
        .ACC_W (ACC_W),
        .IDX_W (IDX_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .div       (div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ftw   (cfg_ftw),
        .cfg_poff  (cfg_poff),
        .lookup    (lookup),
        .en        (en),
        .wrap      (wrap),
        .busy      (busy)
    );

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_idle_cfg(input logic [ACC_W-1:0] ftw, input logic [IDX_W-1:0] poff);
        cfg_valid = 1'b1;
        cfg_ftw   = ftw;
        cfg_poff  = poff;
        vec_cnt++;
        if (cfg_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL idle_cfg_ready: got %b want 1", cfg_ready);
        end
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        vec_cnt++;
        if ({lookup, en, wrap, busy, cfg_ready} !== {7'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            err_cnt++;
            $display("FAIL reset_state: got lookup=%0d en=%b wrap=%b busy=%b rdy=%b want 0 0 0 0 1",
                     lookup, en, wrap, busy, cfg_ready);
        end
        rst_n = 1'b1;
        step(2);
        vec_cnt++;
        if ({en, busy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL reset_release: got en=%b busy=%b want 0 0", en, busy);
        end
    endtask

    task automatic test_ramp();
        logic [IDX_W-1:0] exp_lk;
        logic             exp_wrap;
        load_idle_cfg(24'h02_0000, 7'd0);
        start = 1'b1;
        div   = 12'd3;
        step(1);
        start = 1'b0;
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL ramp_busy: got %b want 1", busy);
        end
        for (int k = 1; k <= 128; k++) begin
            for (int c = 0; c < 3; c++) begin
                step(1);
                vec_cnt++;
                if (en !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL ramp_gap: sample %0d cycle %0d got en=%b want 0", k, c, en);
                end
            end
            step(1);
            exp_lk   = IDX_W'(k);
            exp_wrap = (k == 128);
            vec_cnt++;
            if ({en, wrap, lookup} !== {1'b1, exp_wrap, exp_lk}) begin
                err_cnt++;
                $display("FAIL ramp_sample %0d: got en=%b wrap=%b lookup=%0d want 1 %b %0d",
                         k, en, wrap, lookup, exp_wrap, exp_lk);
            end
        end
    endtask

    task automatic test_stop();
        step(1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        vec_cnt++;
        if ({busy, en} !== 2'b10) begin
            err_cnt++;
            $display("FAIL stop_pending: got busy=%b en=%b want 1 0", busy, en);
        end
        step(1);
        vec_cnt++;
        if (en !== 1'b0) begin
            err_cnt++;
            $display("FAIL stop_gap: got en=%b want 0", en);
        end
        step(1);
        vec_cnt++;
        if ({en, wrap, lookup, busy} !== {1'b1, 1'b0, 7'd1, 1'b0}) begin
            err_cnt++;
            $display("FAIL stop_final: got en=%b wrap=%b lookup=%0d busy=%b want 1 0 1 0",
                     en, wrap, lookup, busy);
        end
        for (int c = 0; c < 6; c++) begin
            step(1);
            vec_cnt++;
            if ({en, wrap, lookup, busy, cfg_ready} !== {1'b0, 1'b0, 7'd1, 1'b0, 1'b1}) begin
                err_cnt++;
                $display("FAIL stop_hold %0d: got en=%b wrap=%b lookup=%0d busy=%b rdy=%b want 0 0 1 0 1",
                         c, en, wrap, lookup, busy, cfg_ready);
            end
        end
    endtask

    task automatic test_fast();
        logic [IDX_W-1:0] exp_lk;
        load_idle_cfg(24'h04_0000, 7'd32);
        start = 1'b1;
        stop  = 1'b1;
        div   = 12'd0;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL fast_start_stop_idle: got busy=%b want 1", busy);
        end
        for (int k = 1; k <= 8; k++) begin
            step(1);
            exp_lk = IDX_W'(32 + 2 * k);
            vec_cnt++;
            if ({en, wrap, lookup} !== {1'b1, 1'b0, exp_lk}) begin
                err_cnt++;
                $display("FAIL fast_sample %0d: got en=%b wrap=%b lookup=%0d want 1 0 %0d",
                         k, en, wrap, lookup, exp_lk);
            end
        end
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        vec_cnt++;
        if ({en, lookup, busy} !== {1'b1, 7'd50, 1'b1}) begin
            err_cnt++;
            $display("FAIL fast_start_stop_run: got en=%b lookup=%0d busy=%b want 1 50 1", en, lookup, busy);
        end
        step(1);
        vec_cnt++;
        if ({en, lookup, busy} !== {1'b1, 7'd52, 1'b0}) begin
            err_cnt++;
            $display("FAIL fast_final: got en=%b lookup=%0d busy=%b want 1 52 0", en, lookup, busy);
        end
        step(1);
        vec_cnt++;
        if ({en, lookup} !== {1'b0, 7'd52}) begin
            err_cnt++;
            $display("FAIL fast_idle: got en=%b lookup=%0d want 0 52", en, lookup);
        end
    endtask

    task automatic test_retune();
        load_idle_cfg(24'h02_0000, 7'd0);
        start = 1'b1;
        div   = 12'd7;
        step(1);
        start = 1'b0;
        step(7);
        vec_cnt++;
        if (en !== 1'b0) begin
            err_cnt++;
            $display("FAIL retune_latency: got en=%b want 0 before cycle 8", en);
        end
        step(1);
        vec_cnt++;
        if ({en, lookup} !== {1'b1, 7'd1}) begin
            err_cnt++;
            $display("FAIL retune_first: got en=%b lookup=%0d want 1 1", en, lookup);
        end
        step(6);
        cfg_valid = 1'b1;
        cfg_ftw   = 24'h08_0000;
        cfg_poff  = 7'd5;
        vec_cnt++;
        if (cfg_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL retune_ready_before: got %b want 1", cfg_ready);
        end
        step(1);
        cfg_ftw  = 24'h10_0000;
        cfg_poff = 7'd0;
        vec_cnt++;
        if (cfg_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL retune_ready_full: got %b want 0", cfg_ready);
        end
        step(1);
        vec_cnt++;
        if ({en, lookup, cfg_ready} !== {1'b1, 7'd2, 1'b1}) begin
            err_cnt++;
            $display("FAIL retune_old_step: got en=%b lookup=%0d rdy=%b want 1 2 1", en, lookup, cfg_ready);
        end
        step(1);
        cfg_valid = 1'b0;
        vec_cnt++;
        if (cfg_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL retune_second_accept: got rdy=%b want 0", cfg_ready);
        end
        step(7);
        vec_cnt++;
        if ({en, lookup, cfg_ready} !== {1'b1, 7'd11, 1'b1}) begin
            err_cnt++;
            $display("FAIL retune_new_step: got en=%b lookup=%0d rdy=%b want 1 11 1", en, lookup, cfg_ready);
        end
        step(8);
        vec_cnt++;
        if ({en, lookup} !== {1'b1, 7'd14}) begin
            err_cnt++;
            $display("FAIL retune_second_word: got en=%b lookup=%0d want 1 14", en, lookup);
        end
    endtask

    task automatic test_reset_mid();
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({lookup, en, wrap, busy, cfg_ready} !== {7'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            err_cnt++;
            $display("FAIL reset_mid_async: got lookup=%0d en=%b wrap=%b busy=%b rdy=%b want 0 0 0 0 1",
                     lookup, en, wrap, busy, cfg_ready);
        end
        step(1);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1);
            vec_cnt++;
            if ({en, busy, lookup} !== {1'b0, 1'b0, 7'd0}) begin
                err_cnt++;
                $display("FAIL reset_mid_quiet %0d: got en=%b busy=%b lookup=%0d want 0 0 0", c, en, busy, lookup);
            end
        end
        start = 1'b1;
        div   = 12'd1;
        step(1);
        start = 1'b0;
        step(1);
        vec_cnt++;
        if (en !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_restart_gap: got en=%b want 0", en);
        end
        step(1);
        vec_cnt++;
        if ({en, wrap, lookup} !== {1'b1, 1'b0, 7'd0}) begin
            err_cnt++;
            $display("FAIL reset_restart_tuning: got en=%b wrap=%b lookup=%0d want 1 0 0", en, wrap, lookup);
        end
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
        vec_cnt++;
        if ({en, busy} !== 2'b10) begin
            err_cnt++;
            $display("FAIL reset_restart_stop: got en=%b busy=%b want 1 0", en, busy);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_stop();
        test_fast();
        test_retune();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "time limit reached");
    end

endmodule

// File: doc/nco_phase_gen.md
NCO_PHASE_GEN -- requirements
Module: nco_phase_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 24, phase accumulator width.
REQ-002 SHALL have parameter IDX_W, default 7, lookup index width matching the sine table address.
REQ-003 SHALL have parameter DIV_W, default 12, sample-period divider width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; all other ports are synchronous to clk.
REQ-005 SHALL have port: clk  in  1  system clock, rising edge.
REQ-006 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port: start  in  1  begin generation (single-cycle pulse).
REQ-008 SHALL have port: stop  in  1  end generation at the next sample boundary.
REQ-009 SHALL have port: div  in  DIV_W  sample period minus 1, sampled when start is accepted.
REQ-010 SHALL have port: cfg_valid  in  1  tuning word offered.
REQ-011 SHALL have port: cfg_ready  out  1  tuning word can be accepted.
REQ-012 SHALL have port: cfg_ftw  in  ACC_W  frequency tuning word.
REQ-013 SHALL have port: cfg_poff  in  IDX_W  phase offset in index units.
REQ-014 SHALL have port: lookup  out  IDX_W  sine table index, registered.
REQ-015 SHALL have port: en  out  1  one-cycle strobe that marks a new lookup value.
REQ-016 SHALL have port: wrap  out  1  one-cycle pulse, coincident with en, when the accumulator carries out.
REQ-017 SHALL have port: busy  out  1  high when the state is not IDLE.

Function
REQ-018 SHALL implement a three-state FSM with states IDLE, RUN and HALT_PEND.
REQ-019 SHALL, in IDLE on start, clear acc to 0, load the tick counter with div, and enter RUN; stop in IDLE SHALL be ignored.
REQ-020 SHALL, in RUN, decrement the tick counter each cycle; a count of 0 is a sample boundary, at which the counter reloads with the captured div.
REQ-021 SHALL, at each sample boundary, compute acc <= acc + ftw_active modulo 2^ACC_W.
REQ-022 SHALL, at each sample boundary, set lookup <= (acc_next[ACC_W-1 -: IDX_W] + poff_active) mod 2^IDX_W and pulse en high for exactly one cycle.
REQ-023 SHALL pulse wrap in the same cycle as en whenever the accumulator addition carries out.
REQ-024 SHALL produce the first en div+1 cycles after start; div=0 SHALL give en on every cycle.
REQ-025 SHALL ignore start in RUN and HALT_PEND.
REQ-026 SHALL, on stop in RUN, enter HALT_PEND; the next boundary emits a final sample and returns to IDLE; stop and start together in RUN act as stop.
REQ-027 SHALL hold lookup at its last value in IDLE and keep en and wrap low.
REQ-028 SHALL, in IDLE, hold cfg_ready=1, and on a cfg_valid&cfg_ready transfer write ftw_active and poff_active directly.
REQ-029 SHALL, in RUN/HALT_PEND, accept a transfer into a one-entry shadow when the shadow is empty (cfg_ready=1) and deassert cfg_ready while the shadow is full.
REQ-030 SHALL apply the shadow to the active registers at the next boundary, after that boundary's addition, and clear it so cfg_ready returns to 1 the following cycle.
REQ-031 SHALL, when a transfer and a boundary coincide with the shadow full, apply the old shadow first and not accept the new word until cfg_ready is asserted again.

Reset
REQ-032 SHALL, on rst_n low, asynchronously set state=IDLE, acc=0, ftw_active=0, poff_active=0, shadow empty, tick counter=0, lookup=0, en=0, wrap=0, busy=0 and cfg_ready=1.
REQ-033 SHALL abort any pending sample on a reset mid-operation, without emitting a further en after release until a new start.

Structure
REQ-034 SHALL place the ACC_W, IDX_W and DIV_W defaults and the state enumeration in the shared package nco_pkg.
REQ-035 SHALL implement the reloadable down-counter that produces sample boundaries as sub-module nco_tick_div.
REQ-036 SHALL connect lookup and en directly to the downstream sine lookup stage without added latency.

Verification
REQ-037 SHALL cover: ftw=2^17, poff=0, div=3, start -> en every 4 cycles, lookup 1,2,3,…,127,0 with wrap only on the sample that gives 0.
REQ-038 SHALL cover: ftw=2^18, poff=32, div=0 -> en every cycle, lookup 34,36,38,….
REQ-039 SHALL cover: during RUN with div=7, new ftw offered -> cfg_ready drops for one cycle after the transfer, step size changes exactly at the next en, and a second offer stalls until cfg_ready is high again.
REQ-040 SHALL cover: stop mid-period -> exactly one more en, then busy=0 and lookup held.
REQ-041 SHALL cover: rst_n low between boundaries -> all outputs go to reset values immediately and there is no en until start.
REQ-042 SHALL cover: start and stop together in IDLE -> run begins; together in RUN -> stop taken.
